// File: rtl/shift_sequencer.sv
// Sequencer for an external shift register: parallel load, WIDTH strobes at one per DIV clocks, then capture.
// Optional abort input enabled by defining SHIFT_SEQUENCER_ABORT_EN.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
`ifdef SHIFT_SEQUENCER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_pdata,
  input  logic [WIDTH-1:0] sr_pout
);

  // Counters hold their terminal values (WIDTH, DIV) without wrapping.
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = $clog2(DIV + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, DONE} state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             abort_req;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    pdata_d   = pdata_q;
    rx_d      = rx_q;
    sr_shift  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    sr_load   = (state_q == LOAD);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pdata_d = tx_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (div_cnt_q == DCW'(DIV - 1)) begin
          sr_shift  = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(WIDTH - 1)) state_d = CAPTURE;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      CAPTURE: begin
        rx_d    = sr_pout;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over the normal transition; rx_data is untouched in these states.
    if (abort_req && (state_q == LOAD || state_q == SHIFT)) state_d = IDLE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      pdata_q   <= '0;
      rx_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      pdata_q   <= pdata_d;
      rx_q      <= rx_d;
    end
  end

  assign sr_pdata = pdata_q;
  assign rx_data  = rx_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: two sequencers (DIV=4 and DIV=1) each driving a behavioural shift register
// fed with random serial bits; timing and captured data are checked against schedule arithmetic.
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int DA = 4;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic reset, start_a, start_b;
  logic [W-1:0] tx_data;
`ifdef SHIFT_SEQUENCER_ABORT_EN
  logic abort;
`endif

  logic busy_a, done_a, sr_load_a, sr_shift_a;
  logic busy_b, done_b, sr_load_b, sr_shift_b;
  logic [W-1:0] rx_a, pdata_a, pout_a, rx_b, pdata_b, pout_b;
  logic [3:0] ctl_a, ctl_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .DIV(DA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data),
`ifdef SHIFT_SEQUENCER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sr_load(sr_load_a),
    .sr_shift(sr_shift_a), .sr_pdata(pdata_a), .sr_pout(pout_a)
  );

  shift_sequencer #(.WIDTH(W), .DIV(DB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data),
`ifdef SHIFT_SEQUENCER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sr_load(sr_load_b),
    .sr_shift(sr_shift_b), .sr_pdata(pdata_b), .sr_pout(pout_b)
  );

  assign ctl_a = {busy_a, done_a, sr_load_a, sr_shift_a};
  assign ctl_b = {busy_b, done_b, sr_load_b, sr_shift_b};

  // External shift registers: parallel load, or shift left taking a random serial bit.
  logic [W-1:0] per_a, per_b;
  bit mq_a[$], mq_b[$];
  bit rb_a, rb_b;
  assign pout_a = per_a;
  assign pout_b = per_b;

  always @(posedge clk) begin
    if (sr_load_a) per_a <= pdata_a;
    else if (sr_shift_a) begin
      rb_a = 1'($urandom);
      per_a <= {per_a[W-2:0], rb_a};
      mq_a.push_back(rb_a);
    end
  end

  always @(posedge clk) begin
    if (sr_load_b) per_b <= pdata_b;
    else if (sr_shift_b) begin
      rb_b = 1'($urandom);
      per_b <= {per_b[W-2:0], rb_b};
      mq_b.push_back(rb_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on DUT a (sel=0) or b (sel=1); cycle 0 is the IDLE cycle with start high.
  task automatic run_xfer(input bit sel, input logic [W-1:0] data,
                          input int rp0, input int rp1, input string tag);
    int d    = sel ? DB : DA;
    int last = 3 + W * d;
    logic [3:0]   exp_v, obs_v;
    logic [W-1:0] exp_rx, obs_rx, obs_pd;
    int nshift;
    if (sel) mq_b.delete(); else mq_a.delete();
    tx_data = data;
    for (int c = 0; c <= last + 1; c++) begin
      if (sel) start_b = (c == 0 || c == rp0 || c == rp1);
      else     start_a = (c == 0 || c == rp0 || c == rp1);
      if (c == rp0 || c == rp1) tx_data = ~data;
      exp_v = {(c >= 1 && c <= last), (c == last), (c == 1),
               (c >= 1 + d && c <= 1 + W * d && (c - 1) % d == 0)};
      obs_v  = sel ? ctl_b : ctl_a;
      obs_rx = sel ? rx_b : rx_a;
      obs_pd = sel ? pdata_b : pdata_a;
      n_total++;
      if (obs_v !== exp_v)
        $display("FAIL %s ctl cycle %0d: got busy/done/load/shift=%b expected %b", tag, c, obs_v, exp_v);
      else n_pass++;
      if (c == last || c == last + 1) begin
        exp_rx = '0;
        if (sel) foreach (mq_b[i]) exp_rx = {exp_rx[W-2:0], mq_b[i]};
        else     foreach (mq_a[i]) exp_rx = {exp_rx[W-2:0], mq_a[i]};
        n_total++;
        if (obs_rx !== exp_rx)
          $display("FAIL %s rx_data cycle %0d: got %h expected %h", tag, c, obs_rx, exp_rx);
        else n_pass++;
      end
      if (c == last) begin
        nshift = sel ? mq_b.size() : mq_a.size();
        n_total++;
        if (nshift != W) $display("FAIL %s shift count: got %0d expected %0d", tag, nshift, W);
        else n_pass++;
        n_total++;
        if (obs_pd !== data) $display("FAIL %s sr_pdata: got %h expected %h", tag, obs_pd, data);
        else n_pass++;
      end
      step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b1; start_b = 1'b1; tx_data = 8'hFF;
    #2;
    n_total++;
    if ({ctl_a, ctl_b, rx_a, rx_b, pdata_a, pdata_b} !== '0)
      $display("FAIL reset_async: got a=%b/%h/%h b=%b/%h/%h expected all zero",
               ctl_a, rx_a, pdata_a, ctl_b, rx_b, pdata_b);
    else n_pass++;
    step(); step();
    n_total++;
    if ({ctl_a, ctl_b, rx_a, rx_b, pdata_a, pdata_b} !== '0)
      $display("FAIL reset_held: got a=%b/%h/%h b=%b/%h/%h expected all zero",
               ctl_a, rx_a, pdata_a, ctl_b, rx_b, pdata_b);
    else n_pass++;
    start_a = 1'b0; start_b = 1'b0;
    reset = 1'b0;
    step();
    n_total++;
    if ({ctl_a, ctl_b} !== '0) $display("FAIL reset_release: got %b expected 0", {ctl_a, ctl_b});
    else n_pass++;
  endtask

  task automatic test_basic();
    run_xfer(1'b0, 8'hA5, -1, -1, "basic_a5");
    for (int i = 0; i < 3; i++) run_xfer(1'b0, W'($urandom), -1, -1, "basic_rand");
  endtask

  task automatic test_div1();
    run_xfer(1'b1, 8'h3C, -1, -1, "div1_3c");
    for (int i = 0; i < 3; i++) run_xfer(1'b1, W'($urandom), -1, -1, "div1_rand");
  endtask

  task automatic test_ignore_start();
    run_xfer(1'b0, 8'hA5, 3, 20, "ignore_start");
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    mq_a.delete();
    tx_data = 8'hA5; start_a = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done_a) dones++;
      step();
      start_a = 1'b0;
    end
    reset = 1'b1;
    #2;
    n_total++;
    if ({ctl_a, rx_a, pdata_a} !== '0)
      $display("FAIL reset_mid_async: got ctl=%b rx=%h pdata=%h expected all zero", ctl_a, rx_a, pdata_a);
    else n_pass++;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done_a) dones++;
      step();
    end
    n_total++;
    if (dones != 0 || busy_a !== 1'b0)
      $display("FAIL reset_mid_abandon: got dones=%0d busy=%b expected 0/0", dones, busy_a);
    else n_pass++;
    run_xfer(1'b0, 8'hA5, -1, -1, "post_reset");
  endtask

  task automatic test_back_to_back();
    int period = W * DA + 4;
    int loads[$], dones[$];
    int got_l, got_d;
    logic [W-1:0] exp_rx;
    tx_data = W'($urandom); start_a = 1'b1;
    mq_a.delete();
    for (int c = 0; c < 3 * period; c++) begin
      if (sr_load_a) loads.push_back(c);
      if (done_a) begin
        dones.push_back(c);
        exp_rx = '0;
        foreach (mq_a[i]) exp_rx = {exp_rx[W-2:0], mq_a[i]};
        n_total++;
        if (rx_a !== exp_rx) $display("FAIL b2b rx_data cycle %0d: got %h expected %h", c, rx_a, exp_rx);
        else n_pass++;
      end
      step();
    end
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got_l = (k < loads.size()) ? loads[k] : -1;
      got_d = (k < dones.size()) ? dones[k] : -1;
      n_total++;
      if (got_l != 1 + k * period || got_d != period - 1 + k * period)
        $display("FAIL b2b timing %0d: got load=%0d done=%0d expected load=%0d done=%0d",
                 k, got_l, got_d, 1 + k * period, period - 1 + k * period);
      else n_pass++;
    end
    n_total++;
    if (loads.size() != 3 || dones.size() != 3)
      $display("FAIL b2b counts: got loads=%0d dones=%0d expected 3/3", loads.size(), dones.size());
    else n_pass++;
    step();
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL b2b stop: got busy=%b expected 0", busy_a);
    else n_pass++;
  endtask

`ifdef SHIFT_SEQUENCER_ABORT_EN
  task automatic test_abort();
    logic [W-1:0] rx_before;
    int strobes_before = 0, strobes_after = 0, dones = 0, busy_after = 0;
    rx_before = rx_a;
    tx_data = W'($urandom); start_a = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      abort = (c == 14);
      if (done_a) dones++;
      if (c < 15 && sr_shift_a) strobes_before++;
      if (c >= 15 && sr_shift_a) strobes_after++;
      if (c >= 15 && busy_a) busy_after++;
      step();
      start_a = 1'b0;
    end
    abort = 1'b0;
    n_total++;
    if (strobes_before != 3 || strobes_after != 0 || dones != 0 || busy_after != 0)
      $display("FAIL abort: got strobes=%0d/%0d dones=%0d busy_cycles=%0d expected 3/0 0 0",
               strobes_before, strobes_after, dones, busy_after);
    else n_pass++;
    n_total++;
    if (rx_a !== rx_before) $display("FAIL abort rx_data: got %h expected %h", rx_a, rx_before);
    else n_pass++;
  endtask
`endif

  initial begin
`ifdef SHIFT_SEQUENCER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_div1();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SHIFT_SEQUENCER_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
